// File: rtl/udp_outbound_chain_arb_if.sv
// Byte-stream bundle for the outbound UDP arbiter: chain input, local
// input with its grant handshake, and the arbitrated output stream.
interface udp_outbound_chain_arb_if;
  logic [7:0]  chain_d;
  logic        chain_dv;
  logic        local_req;
  logic        local_grant;
  logic [7:0]  local_d;
  logic        local_dv;
  logic [7:0]  txd;
  logic        txdv;
  logic [15:0] drop_cnt;
  logic        busy;

  modport slave (
    input  chain_d, chain_dv, local_req, local_d, local_dv,
    output local_grant, txd, txdv, drop_cnt, busy
  );

  modport master (
    output chain_d, chain_dv, local_req, local_d, local_dv,
    input  local_grant, txd, txdv, drop_cnt, busy
  );
endinterface

// File: rtl/udp_outbound_chain_arb.sv
// Round-robin scheduler of the outbound UDP byte stream: chain frames are
// stored and forwarded through a byte FIFO, local frames stream after a grant.
module udp_outbound_chain_arb #(
  parameter int FIFO_AW  = 11,
  parameter int IFG      = 12,
  parameter int GRANT_TO = 16
) (
  input  logic                     c,
  input  logic                     rst,
  udp_outbound_chain_arb_if.slave  bus
);

  localparam int GW = $clog2(IFG + 1);
  localparam int TW = $clog2(GRANT_TO + 1);
  localparam logic [FIFO_AW:0] DEPTH_P   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [GW-1:0]    GAP_LAST  = GW'(IFG - 1);
  localparam logic [TW-1:0]    TO_LAST   = TW'(GRANT_TO - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_LWAIT = 3'd2,
    ST_LOCAL = 3'd3,
    ST_CHAIN = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  typedef enum logic {
    SRC_LOCAL = 1'b0,
    SRC_CHAIN = 1'b1
  } src_e;

  logic [8:0]         mem_q [DEPTH_P];
  logic [8:0]         rdata_q;

  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   frame_start_q, frame_start_d;
  logic [FIFO_AW:0]   frames_pending_q, frames_pending_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_v_q, hold_v_d;
  logic               dropping_q, dropping_d;
  logic               skip_q, skip_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               rvalid_q, rvalid_d;

  state_e             state_q, state_d;
  src_e               rr_last_q, rr_last_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]      to_cnt_q, to_cnt_d;
  logic [7:0]         txd_q, txd_d;
  logic               txdv_q, txdv_d;
  logic               grant_q, grant_d;
  logic               busy_q, busy_d;

  logic               cdv_s, wr_try_s, eof_s, full_s, mem_we_s, commit_s;
  logic               rd_en_s, pop_eof_s;

  // Chain write side: one-byte hold stage decides eof, overflow drops the whole frame.
  always_comb begin
    skip_d        = skip_q & bus.chain_dv;
    cdv_s         = bus.chain_dv & ~skip_q;
    wr_try_s      = hold_v_q;
    eof_s         = ~cdv_s;
    full_s        = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    mem_we_s      = wr_try_s & ~full_s & ~dropping_q;
    commit_s      = mem_we_s & eof_s;
    wr_ptr_d      = wr_ptr_q;
    frame_start_d = frame_start_q;
    dropping_d    = dropping_q;
    drop_cnt_d    = drop_cnt_q;
    hold_v_d      = cdv_s;
    if (cdv_s) begin
      hold_d = bus.chain_d;
    end else begin
      hold_d = hold_q;
    end
    if (mem_we_s) begin
      wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
      if (eof_s) begin
        frame_start_d = wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
        frame_start_d = frame_start_q;
      end
    end else if (wr_try_s) begin
      if (eof_s) begin
        wr_ptr_d   = frame_start_q;
        dropping_d = 1'b0;
        if (drop_cnt_q != 16'hffff) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
      end else begin
        dropping_d = 1'b1;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Read side: the read that would follow an eof entry is suppressed, so no rewind is needed.
  always_comb begin
    rd_en_s          = (state_q == ST_CHAIN) & ~(rvalid_q & rdata_q[8]);
    pop_eof_s        = rvalid_q & rdata_q[8];
    rvalid_d         = rd_en_s;
    rd_ptr_d         = rd_ptr_q + {{FIFO_AW{1'b0}}, rd_en_s};
    frames_pending_d = frames_pending_q + {{FIFO_AW{1'b0}}, commit_s}
                                        - {{FIFO_AW{1'b0}}, pop_eof_s};
  end

  // Scheduler next-state and registered output stream.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gap_cnt_d = '0;
    to_cnt_d  = '0;
    txd_d     = 8'd0;
    txdv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((frames_pending_q != '0) && bus.local_req) begin
          state_d = (rr_last_q == SRC_LOCAL) ? ST_CHAIN : ST_GRANT;
        end else if (frames_pending_q != '0) begin
          state_d = ST_CHAIN;
        end else if (bus.local_req) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_d = ST_LWAIT;
      end
      ST_LWAIT: begin
        if (bus.local_dv) begin
          txd_d   = bus.local_d;
          txdv_d  = 1'b1;
          state_d = ST_LOCAL;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      ST_LOCAL: begin
        if (bus.local_dv) begin
          txd_d  = bus.local_d;
          txdv_d = 1'b1;
        end else begin
          state_d   = ST_GAP;
          rr_last_d = SRC_LOCAL;
        end
      end
      ST_CHAIN: begin
        if (rvalid_q) begin
          txd_d  = rdata_q[7:0];
          txdv_d = 1'b1;
          if (rdata_q[8]) begin
            state_d   = ST_GAP;
            rr_last_d = SRC_CHAIN;
          end else begin
            state_d = ST_CHAIN;
          end
        end else begin
          state_d = ST_CHAIN;
        end
      end
      ST_GAP: begin
        // The gap counts only cycles with txdv already low.
        if (!txdv_q) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + {{(GW-1){1'b0}}, 1'b1};
          end
        end else begin
          gap_cnt_d = gap_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    grant_d = (state_d == ST_GRANT);
    busy_d  = (state_d != ST_IDLE);
  end

  // FIFO storage and registered read port; contents need no reset.
  always_ff @(posedge c) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {eof_s, hold_q};
    end
    if (rd_en_s) begin
      rdata_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge c) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      frame_start_q    <= '0;
      frames_pending_q <= '0;
      hold_q           <= 8'd0;
      hold_v_q         <= 1'b0;
      dropping_q       <= 1'b0;
      skip_q           <= 1'b1;
      drop_cnt_q       <= 16'd0;
      rvalid_q         <= 1'b0;
      state_q          <= ST_IDLE;
      rr_last_q        <= SRC_LOCAL;
      gap_cnt_q        <= '0;
      to_cnt_q         <= '0;
      txd_q            <= 8'd0;
      txdv_q           <= 1'b0;
      grant_q          <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      frame_start_q    <= frame_start_d;
      frames_pending_q <= frames_pending_d;
      hold_q           <= hold_d;
      hold_v_q         <= hold_v_d;
      dropping_q       <= dropping_d;
      skip_q           <= skip_d;
      drop_cnt_q       <= drop_cnt_d;
      rvalid_q         <= rvalid_d;
      state_q          <= state_d;
      rr_last_q        <= rr_last_d;
      gap_cnt_q        <= gap_cnt_d;
      to_cnt_q         <= to_cnt_d;
      txd_q            <= txd_d;
      txdv_q           <= txdv_d;
      grant_q          <= grant_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.txd         = txd_q;
  assign bus.txdv        = txdv_q;
  assign bus.local_grant = grant_q;
  assign bus.drop_cnt    = drop_cnt_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_udp_outbound_chain_arb.sv
// Scoreboard bench for udp_outbound_chain_arb: a frame-level round-robin model
// queues expected output bytes, a negedge monitor pops and compares them.
module tb_udp_outbound_chain_arb;
  localparam int AW  = 6;
  localparam int IFG = 12;
  localparam int GTO = 16;

  logic c = 1'b0;
  logic rst;
  always #5 c = ~c;

  udp_outbound_chain_arb_if bus();

  udp_outbound_chain_arb #(.FIFO_AW(AW), .IFG(IFG), .GRANT_TO(GTO)) dut (
    .c   (c),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  logic [7:0] cbuf[$];
  logic [7:0] lbuf[$];
  bit         mon_en = 1'b1;
  bit         rr_chain_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Monitor: pops an expected byte for every valid output byte.
  initial begin
    int  idle_run = 1000;
    bit  prev_dv  = 1'b0;
    bit  prev_eof = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge c);
      if (rst) begin
        idle_run = 1000;
        prev_dv  = 1'b0;
        prev_eof = 1'b0;
      end else if (mon_en) begin
        if (bus.txdv && !prev_dv) chk("ifg_min", 32'(idle_run >= IFG), 32'd1);
        if (bus.txdv) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t", bus.txd, $time);
          end else begin
            e = exp_q.pop_front();
            chk("txd", 32'(bus.txd), 32'(e[7:0]));
            if (prev_dv) chk("no_merge", 32'(prev_eof), 32'd0);
            prev_eof = e[8];
          end
        end else if (prev_dv) begin
          chk("frame_end_eof", 32'(prev_eof), 32'd1);
          chk("txd_idle_zero", 32'(bus.txd), 32'd0);
        end
        idle_run = bus.txdv ? 0 : idle_run + 1;
        prev_dv  = bus.txdv;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic fill_c(input int len, input bit rnd);
    cbuf.delete();
    for (int i = 0; i < len; i++) cbuf.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
  endtask

  task automatic fill_l(input int len);
    lbuf.delete();
    for (int i = 0; i < len; i++) lbuf.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic push_c();
    for (int i = 0; i < cbuf.size(); i++) exp_q.push_back({(i == cbuf.size() - 1), cbuf[i]});
  endtask

  task automatic push_l();
    for (int i = 0; i < lbuf.size(); i++) exp_q.push_back({(i == lbuf.size() - 1), lbuf[i]});
  endtask

  // Streams cbuf as one contiguous chain frame; returns in the cycle chain_dv is low.
  task automatic send_chain();
    for (int i = 0; i < cbuf.size(); i++) begin
      tick();
      bus.chain_dv = 1'b1;
      bus.chain_d  = cbuf[i];
    end
    tick();
    bus.chain_dv = 1'b0;
    bus.chain_d  = 8'd0;
  endtask

  // Requests a grant, then streams lbuf (or withholds local_dv to force the timeout).
  task automatic local_frame(input int dly, input bit timeout);
    int n = 0;
    tick();
    bus.local_req = 1'b1;
    while (!bus.local_grant && n < 4000) begin
      @(negedge c);
      n++;
    end
    if (!bus.local_grant) begin
      bound_fail("grant_wait");
      bus.local_req = 1'b0;
    end else begin
      tick();
      bus.local_req = 1'b0;
      @(negedge c);
      chk("grant_pulse", 32'(bus.local_grant), 32'd0);
      if (timeout) begin
        repeat (GTO - 1) @(negedge c);
        chk("lwait_busy", 32'(bus.busy), 32'd1);
        @(negedge c);
        chk("timeout_idle", 32'(bus.busy), 32'd0);
      end else begin
        repeat (dly) tick();
        for (int i = 0; i < lbuf.size(); i++) begin
          tick();
          bus.local_dv = 1'b1;
          bus.local_d  = lbuf[i];
          @(negedge c);
          if (i == 0) chk("local_pre", 32'(bus.txdv), 32'd0);
          else        chk("local_latency", 32'(bus.txd), 32'(lbuf[i-1]));
        end
        tick();
        bus.local_dv = 1'b0;
        bus.local_d  = 8'd0;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 5000) begin
      @(negedge c);
      n++;
    end
    if (n >= 5000) bound_fail("wait_idle");
    tick();
  endtask

  // Both sources ready in the same idle cycle: the model picks the source that did not go last.
  task automatic contention(input int clen, input int llen);
    fill_c(clen, 1'b1);
    fill_l(llen);
    if (!rr_chain_last) begin
      push_c();
      push_l();
      rr_chain_last = 1'b0;
    end else begin
      push_l();
      push_c();
      rr_chain_last = 1'b1;
    end
    send_chain();
    local_frame($urandom_range(0, 10), 1'b0);
  endtask

  initial begin
    int n;
    int kind;
    bus.chain_d   = 8'd0;
    bus.chain_dv  = 1'b0;
    bus.local_req = 1'b0;
    bus.local_d   = 8'd0;
    bus.local_dv  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge c);
    chk("rst_txd", 32'(bus.txd), 32'd0);
    chk("rst_txdv", 32'(bus.txdv), 32'd0);
    chk("rst_grant", 32'(bus.local_grant), 32'd0);
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();

    // Chain-only 64-byte frame 00..3f: nothing leaves before the frame is complete.
    fill_c(64, 1'b0);
    push_c();
    send_chain();
    rr_chain_last = 1'b1;
    @(negedge c);
    chk("store_and_forward", 32'(bus.txdv), 32'd0);
    n = 0;
    while (!bus.txdv && n < 10) begin
      @(negedge c);
      n++;
    end
    if (!bus.txdv) bound_fail("chain_start");
    wait_idle();

    // Local-only 20-byte frame, then busy timing across the gap.
    fill_l(20);
    push_l();
    local_frame(2, 1'b0);
    rr_chain_last = 1'b0;
    n = 0;
    while (bus.txdv && n < 10) begin
      @(negedge c);
      n++;
    end
    repeat (IFG - 1) @(negedge c);
    chk("gap_busy", 32'(bus.busy), 32'd1);
    @(negedge c);
    chk("gap_done_idle", 32'(bus.busy), 32'd0);
    wait_idle();

    // Contention twice in a row with the same tie.
    contention(30, 20);
    wait_idle();
    contention(15, 10);
    wait_idle();

    // Grant timeout while a chain frame arrives; the chain frame follows.
    fill_c(8, 1'b1);
    push_c();
    fork
      local_frame(0, 1'b1);
      begin
        repeat (2) tick();
        send_chain();
      end
    join
    rr_chain_last = 1'b1;
    wait_idle();

    // Overflow: oversized frame dropped, next frame intact.
    fill_c(80, 1'b1);
    send_chain();
    repeat (2) tick();
    fill_c(10, 1'b1);
    push_c();
    send_chain();
    wait_idle();
    chk("drop_cnt_one", 32'(bus.drop_cnt), 32'd1);

    // Reset while the chain frame is on the wire, with a second frame still queued.
    mon_en = 1'b0;
    fill_c(40, 1'b1);
    send_chain();
    fork
      begin
        fill_c(8, 1'b1);
        send_chain();
      end
      begin
        n = 0;
        while (!bus.txdv && n < 20) begin
          @(negedge c);
          n++;
        end
        if (!bus.txdv) bound_fail("reset_frame_start");
        repeat (29) @(negedge c);
      end
    join
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge c);
    chk("midrst_txdv", 32'(bus.txdv), 32'd0);
    chk("midrst_txd", 32'(bus.txd), 32'd0);
    chk("midrst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    rr_chain_last = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();
    fill_c(12, 1'b1);
    push_c();
    send_chain();
    rr_chain_last = 1'b1;
    wait_idle();

    // Randomised mix of the four traffic patterns.
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          fill_c($urandom_range(1, 40), 1'b1);
          push_c();
          send_chain();
          rr_chain_last = 1'b1;
        end
        1: begin
          fill_l($urandom_range(1, 30));
          push_l();
          local_frame($urandom_range(0, 10), 1'b0);
          rr_chain_last = 1'b0;
        end
        2: begin
          contention($urandom_range(1, 40), $urandom_range(1, 30));
        end
        default: begin
          fill_l($urandom_range(1, 30));
          fill_c($urandom_range(1, 40), 1'b1);
          push_l();
          push_c();
          fork
            local_frame($urandom_range(0, 10), 1'b0);
            begin
              repeat (3) tick();
              send_chain();
            end
          join
          rr_chain_last = 1'b1;
        end
      endcase
      wait_idle();
    end

    chk("drop_cnt_final", 32'(bus.drop_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
